// File: rtl/weyl_stream_gen.sv
`default_nettype none
// =============================================================================
// Module   : weyl_stream_gen
// Purpose  : Multi-channel stochastic bitstream generator using a Weyl index
//            map; optional macro WEYL_DECORR_EN gives each channel its own offset.
// Revision : 1.0 - initial release
// =============================================================================
module weyl_stream_gen #(
    parameter int BITSTREAM = 64,
    parameter int BASE      = 61,
    parameter int STRIDE    = 17,
    parameter int LANES     = 8,
    parameter int CHANNELS  = 2,
    parameter int CH_SHIFT  = 23
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [CHANNELS*($clog2(BITSTREAM)+1)-1:0]    in_quota,
    input  logic                                         abort,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [CHANNELS*LANES-1:0]                    out_data,
    output logic                                         out_last
);
    localparam int C_LW = $clog2(BITSTREAM);
    localparam int C_QW = C_LW + 1;
    localparam int C_NB = BITSTREAM / LANES;
    localparam int C_BW = $clog2(C_NB) + 1;
`ifdef WEYL_DECORR_EN
    localparam int C_NACC = CHANNELS;
`else
    localparam int C_NACC = 1;
`endif

    function automatic int f_inv();
        int r = 0;
        for (int x = 1; x < BITSTREAM; x++)
            if (r == 0 && ((STRIDE * x) % BITSTREAM) == 1) r = x;
        return r;
    endfunction

    localparam int C_INV = f_inv();

    // Start index of accumulator a: (-BASE*INV + a*CH_SHIFT) mod N
    function automatic int f_start(int a);
        int base_idx;
        base_idx = (BITSTREAM - (((BASE % BITSTREAM) * C_INV) % BITSTREAM)) % BITSTREAM;
        return (base_idx + a * CH_SHIFT) % BITSTREAM;
    endfunction

    localparam logic [C_LW-1:0] C_STEP = C_LW'((LANES * C_INV) % BITSTREAM);

    if (STRIDE % 2 == 0) begin : g_err_stride
        $error("weyl_stream_gen: STRIDE must be odd");
    end
    if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_err_len
        $error("weyl_stream_gen: BITSTREAM must be a power of two >= 2");
    end
    if (LANES < 1 || (LANES & (LANES - 1)) != 0 || LANES > BITSTREAM) begin : g_err_lanes
        $error("weyl_stream_gen: LANES must be a power of two dividing BITSTREAM");
    end

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t                    r_state;
    logic [C_BW-1:0]           r_beat;
    logic [C_LW-1:0]           w_base [C_NACC];
    logic [CHANNELS*LANES-1:0] w_beat;
    logic                      w_fire;
    logic                      w_fire_last;
    logic                      w_accept;
    logic                      w_restart;
    logic                      w_step;

    assign w_fire      = out_valid & out_ready;
    assign w_fire_last = w_fire & out_last;
    assign in_ready    = ((r_state == S_IDLE) | w_fire_last) & ~abort;
    assign w_accept    = in_valid & in_ready;
    assign w_restart   = abort | (w_fire_last & ~w_accept);
    assign w_step      = w_accept | (w_fire & ~out_last & ~abort);

    // Accumulators hold the index of the first bit of the next beat to build.
    for (genvar a = 0; a < C_NACC; a++) begin : g_acc
        localparam logic [C_LW-1:0] C_START = C_LW'(f_start(a));
        logic [C_LW-1:0] r_acc;

        assign w_base[a] = w_accept ? C_START : r_acc;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= C_START;
            end else if (w_restart) begin
                r_acc <= C_START;
            end else if (w_step) begin
                r_acc <= w_base[a] + C_STEP;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam int C_A = (C_NACC == 1) ? 0 : c;
        logic [C_QW-1:0] w_raw;
        logic [C_QW-1:0] w_clamp;
        logic [C_QW-1:0] w_quota;
        logic [C_QW-1:0] r_quota;

        assign w_raw   = in_quota[c*C_QW +: C_QW];
        assign w_clamp = (w_raw > C_QW'(BITSTREAM)) ? C_QW'(BITSTREAM) : w_raw;
        assign w_quota = w_accept ? w_clamp : r_quota;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_quota <= '0;
            end else if (w_accept) begin
                r_quota <= w_clamp;
            end
        end

        for (genvar j = 0; j < LANES; j++) begin : g_lane
            localparam logic [C_LW-1:0] C_OFF = C_LW'((j * C_INV) % BITSTREAM);
            logic [C_LW-1:0] w_idx;

            assign w_idx                = w_base[C_A] + C_OFF;
            assign w_beat[c*LANES + j]  = ({1'b0, w_idx} < w_quota);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (w_accept) begin
            r_state   <= S_RUN;
            r_beat    <= C_BW'(1);
            out_valid <= 1'b1;
            out_last  <= (C_NB == 1);
            out_data  <= w_beat;
        end else if (w_fire) begin
            if (out_last) begin
                r_state   <= S_IDLE;
                r_beat    <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                r_beat    <= r_beat + C_BW'(1);
                out_last  <= (r_beat == C_BW'(C_NB - 1));
                out_data  <= w_beat;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_weyl_stream_gen.sv
`default_nettype none
// Testbench for weyl_stream_gen: scoreboard of per-beat expectations built
// from the index-map definition, checked by an independent monitor.
module tb_weyl_stream_gen;
    localparam int N = 64, BASE = 61, STRIDE = 17, L = 8, CH = 2, CH_SHIFT = 23;
    localparam int QW = 7, NB = N / L, W = CH * L;
`ifdef WEYL_DECORR_EN
    localparam int DECORR = 1;
`else
    localparam int DECORR = 0;
`endif

    function automatic int find_inv();
        int r = 0;
        for (int x = 1; x < N; x++)
            if (r == 0 && (STRIDE * x) % N == 1) r = x;
        return r;
    endfunction
    localparam int INV = find_inv();

    typedef struct packed { logic [W-1:0] data; logic last; } beat_t;
    typedef struct packed { int q0; int q1; } frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2*QW-1:0] in_quota = '0;
    logic          abort = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;

    int n_checks = 0;
    int n_errors = 0;
    beat_t  exp_q[$];
    frame_t fr_q[$];
    int beat_idx = 0;
    int pc0 = 0, pc1 = 0;
    logic anydiff = 1'b0;
    logic held = 1'b0;
    logic [W-1:0] hd;
    logic hl;
    logic post_cancel = 1'b0;
    logic stall_req = 1'b0;
    logic rand_ready = 1'b0;
    int stall_left = 0;

    weyl_stream_gen #(
        .BITSTREAM(N), .BASE(BASE), .STRIDE(STRIDE),
        .LANES(L), .CHANNELS(CH), .CH_SHIFT(CH_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_quota(in_quota), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampq(int q);
        return (q < N) ? q : N;
    endfunction

    // Bit p of channel c is 1 iff idx(p) < min(quota, N)
    function automatic logic ref_bit(int q, int c, int p);
        int idx;
        idx = ((p - BASE) * INV) % N;
        if (idx < 0) idx += N;
        idx = (idx + DECORR * c * CH_SHIFT) % N;
        return idx < clampq(q);
    endfunction

    function automatic logic [W-1:0] model_beat(int q0, int q1, int b);
        logic [W-1:0] d;
        for (int j = 0; j < L; j++) begin
            d[j]     = ref_bit(q0, 0, b * L + j);
            d[L + j] = ref_bit(q1, 1, b * L + j);
        end
        return d;
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        fr_q.delete();
        beat_idx = 0; pc0 = 0; pc1 = 0; anydiff = 1'b0; held = 1'b0;
        post_cancel = 1'b1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 64'(out_valid), 64'(0));
            check("rst_last", 64'(out_last), 64'(0));
            check("rst_data", 64'(out_data), 64'(0));
            check("rst_in_ready", 64'(in_ready), 64'(1));
            clear_sb();
        end else if (abort) begin
            check("abort_in_ready", 64'(in_ready), 64'(0));
            clear_sb();
        end else begin
            if (post_cancel) begin
                check("cancel_valid", 64'(out_valid), 64'(0));
                check("cancel_in_ready", 64'(in_ready), 64'(1));
                post_cancel = 1'b0;
            end
            if (held) begin
                check("hold_data", 64'(out_data), 64'(hd));
                check("hold_last", 64'(out_last), 64'(hl));
                held = 1'b0;
            end
            check("valid_vs_pending", 64'(out_valid), 64'(exp_q.size() > 0));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", 64'(out_data), 64'(e.data));
                check("beat_last", 64'(out_last), 64'(e.last));
                pc0 += $countones(out_data[L-1:0]);
                pc1 += $countones(out_data[W-1:L]);
                if (out_data[L-1:0] != out_data[W-1:L]) anydiff = 1'b1;
                beat_idx++;
                if (e.last) begin
                    frame_t f;
                    f = fr_q.pop_front();
                    check("popcount_ch0", 64'(pc0), 64'(clampq(f.q0)));
                    check("popcount_ch1", 64'(pc1), 64'(clampq(f.q1)));
                    if (f.q0 == 32 && f.q1 == 32)
                        check("channel_decorr", 64'(anydiff), 64'(DECORR));
                    pc0 = 0; pc1 = 0; anydiff = 1'b0; beat_idx = 0;
                end
            end else if (out_valid) begin
                held = 1'b1; hd = out_data; hl = out_last;
            end
            if (in_valid && in_ready) begin
                frame_t f;
                f.q0 = int'(in_quota[QW-1:0]);
                f.q1 = int'(in_quota[2*QW-1:QW]);
                fr_q.push_back(f);
                for (int b = 0; b < NB; b++) begin
                    beat_t e;
                    e.data = model_beat(f.q0, f.q1, b);
                    e.last = (b == NB - 1);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Consumer: optional random back-pressure and a directed 3-cycle stall at beat 3
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_req && out_valid && beat_idx == 3) begin
                stall_req = 1'b0;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic send(input int q0, input int q1);
        int t = 0;
        in_quota = {QW'(q1), QW'(q0)};
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_beat(input int k);
        int t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!(out_valid && beat_idx == k) && t < 200);
        if (!(out_valid && beat_idx == k)) check("beat_wait_timeout", 64'(beat_idx), 64'(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        send(20, 19);
        send(5, 4);
        send(0, 64);
        send(127, 64);
        send(32, 32);
        stall_req = 1'b1;
        send(33, 10);
        send(40, 9);
        wait_beat(4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(posedge clk); #1;

        send(12, 50);
        wait_beat(2);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(32, 32);
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
            end
            send(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
        end
        send(32, 32);

        for (int t = 0; t < 2000 && exp_q.size() > 0; t++) @(posedge clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/weyl_stream_gen.md
WEYL_STREAM_GEN -- requirements
Module: weyl_stream_gen

Interface
REQ-001 SHALL have parameter BITSTREAM, default 64, frame length N in bits; power of two, at least 2.
REQ-002 SHALL have parameter BASE, default 61, phase offset of the Weyl index map.
REQ-003 SHALL have parameter STRIDE, default 17, odd Weyl stride; an even value SHALL be an elaboration error.
REQ-004 SHALL have parameter LANES, default 8, bits emitted per beat; power of two that divides BITSTREAM.
REQ-005 SHALL have parameter CHANNELS, default 2, count of independent output streams.
REQ-006 SHALL have parameter CH_SHIFT, default 23, per-channel index offset, used only under REQ-028.
REQ-007 SHALL have port clk  input  1  the only clock; all logic rises on its positive edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-009 SHALL have port in_valid  input  1  a quota vector is offered.
REQ-010 SHALL have port in_ready  output  1  the block accepts a quota vector.
REQ-011 SHALL have port in_quota  input  CHANNELS*(log2(N)+1)  per-channel quota; channel c occupies slice c.
REQ-012 SHALL have port abort  input  1  synchronous frame cancel.
REQ-013 SHALL have port out_valid  output  1  out_data holds a valid beat.
REQ-014 SHALL have port out_ready  input  1  the consumer takes the beat.
REQ-015 SHALL have port out_data  output  CHANNELS*LANES  channel c occupies slice c; lane j is bit position b*LANES+j of beat b.
REQ-016 SHALL have port out_last  output  1  high on the final beat of a frame.

Function
REQ-017 SHALL define bit p of channel c as 1 if and only if idx(p) < min(quota_c, N), where idx(p) = ((p - BASE) * INV) mod N and INV is the inverse of STRIDE mod N, computed at elaboration (N=64, STRIDE=17 gives INV=49).
REQ-018 SHALL derive idx with an accumulator: frame start value (-BASE*INV) mod N; add INV mod N per bit position; use no multiplier in the datapath.
REQ-019 SHALL use FSM states IDLE and RUN only.
REQ-020 SHALL transition IDLE -> RUN on in_valid & in_ready, latch all quotas and clamp each to N.
REQ-021 SHALL transition RUN -> IDLE on the handshake of the out_last beat, unless a new vector is accepted in that same cycle; then SHALL stay in RUN and restart at beat 0 with no bubble.
REQ-022 SHALL drive in_ready = IDLE | (out_valid & out_ready & out_last) & !abort.
REQ-023 SHALL register out_data and present beat 0 in the cycle after acceptance (latency 1).
REQ-024 SHALL advance to beat b+1 only on out_valid & out_ready, so a frame has exactly N/LANES beats.
REQ-025 SHALL hold out_data, out_last and out_valid stable while out_valid & !out_ready.
REQ-026 SHALL, on abort, return to IDLE on the next edge with out_valid=0 and discard the frame; abort SHALL win over any simultaneous handshake.
REQ-027 SHALL produce exactly min(quota_c, N) ones per frame per channel; quota 0 gives all zeros, quota >= N gives all ones.

Configuration
REQ-028 SHALL, with macro WEYL_DECORR_EN defined, give channel c the start index ((-BASE*INV) + c*CH_SHIFT) mod N, decorrelating the channels.
REQ-029 SHALL, without WEYL_DECORR_EN, share one accumulator across all channels, so equal quotas give bit-identical streams; CH_SHIFT is then unused.

Reset
REQ-030 SHALL, while rst_n=0, set state=IDLE, out_valid=0, out_last=0, out_data=0, accumulator=start value and latched quotas=0.
REQ-031 SHALL drive in_ready=1 during and after reset, because the state is IDLE.
REQ-032 SHALL, on reset asserted mid-frame, discard the frame immediately with no partial beat after release.

Verification (N=64, BASE=61, STRIDE=17, LANES=8, CHANNELS=2)
REQ-033 SHALL cover: quota {20,19} accepted -> next cycle out_valid=1, beat0 bit0 ch0=1, ch1=0 (idx(0)=19).
REQ-034 SHALL cover: quota {5,4} -> beat0 bit1 ch0=1, ch1=0 (idx(1)=4); 8 beats, out_last only on beat 7; popcount per frame 5 and 4.
REQ-035 SHALL cover: quota {0,64} and {127,64} -> all-zero/all-ones streams; 127 clamps to all ones.
REQ-036 SHALL cover: out_ready low for 3 cycles at beat 3 -> out_data stable, frame still 8 beats, popcount unchanged.
REQ-037 SHALL cover: new vector offered during the last-beat handshake -> accepted that cycle, new beat0 the next cycle, no idle gap.
REQ-038 SHALL cover: abort at beat 4, and separately rst_n low at beat 2 -> out_valid=0 next edge, in_ready=1, no residual beats; WEYL_DECORR_EN on vs off with quota {32,32} -> streams differ vs identical.
